dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder: the target end of the processor's data-memory request interface. It accepts one load or store at a time, asserts `stall` for the full access latency so the processor pipeline freezes, and then presents read data and completion status for exactly one cycle. It replaces the zero-latency data memory whose stall line is tied low. It lets the processor's stall path be exercised against a memory with realistic latency.

## Interface
- `ADDR_W`, default 10: word-index width. Storage depth is 2^ADDR_W 32-bit words.
- `LATENCY`, default 4: number of BUSY cycles per access. Legal range is 1..255.
- `clk`  input  1  the single clock. All state updates occur on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `enable`  input  1  request valid. Held stable by the processor while `stall`=1.
- `wr`  input  1  1 = store, 0 = load.
- `addr`  input  32  byte address.
- `data_in`  input  32  store data.
- `data_out`  output  32  load data. Registered.
- `stall`  output  1  processor must hold its current request and pipeline.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  misaligned-access flag. Valid only while `done`=1.

## Operation
- The state machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - `stall` = `enable`, combinational, so the request cycle itself is stalled.
  - If `enable`=1 at the clock edge, capture `addr`, `wr` and `data_in`, load the down-counter with LATENCY-1, and go to BUSY.
  - If `enable`=0, stay in IDLE.
- BUSY:
  - `stall`=1. All inputs are ignored; only the captured copies are used.
  - If counter≠0, decrement it and stay in BUSY.
  - If counter=0, perform the access on this edge and go to DONE.
- The access:
  - Word index = captured `addr[ADDR_W+1:2]`. Upper address bits are ignored, so addresses alias modulo 4·2^ADDR_W bytes.
  - Aligned store: write the captured `data_in` to that word. `data_out` is unchanged.
  - Aligned load: `data_out` ← mem[index].
  - Misaligned access (`addr[1:0]`≠0): no write. A load sets `data_out` ← 0. `err` ← 1.
- DONE:
  - `stall`=0, `done`=1, and `err` is as computed during the access.
  - `enable` is ignored in this state; it still carries the request just completed.
  - Unconditionally go to IDLE on the next edge.
  - `done` and `err` clear when leaving DONE. `data_out` holds until the next load completes.
- Storage is not reset; contents are undefined until written.

## Timing
- Request first presented in cycle 0, accepted at the end of cycle 0.
- BUSY occupies cycles 1..LATENCY.
- DONE occurs in cycle LATENCY+1.
- `stall` is high for exactly LATENCY+1 cycles (cycles 0..LATENCY).
- Back-to-back requests: a new request presented in the cycle after DONE is accepted in that IDLE cycle. There are no extra dead cycles; each access occupies LATENCY+2 cycles.
- A load's data is readable on `data_out` in the DONE cycle. A store is visible to a load accepted in the very next IDLE cycle.
- Reset values while `rst`=0, taking effect immediately (asynchronously):
  - state = IDLE, counter = 0
  - `data_out` = 0, `done` = 0, `err` = 0
  - `stall` = 0, forced regardless of `enable`
- Reset asserted mid-BUSY aborts the access: no write occurs and no `done` pulse is produced.
- Reset released with `enable`=1: the request is accepted at the first rising edge after release.

## Test plan
- LATENCY=4. Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010:
  - `stall` is high for 5 cycles per access.
  - `done` pulses in cycle 5 of each access.
  - The load returns `data_out`=0xDEADBEEF with `err`=0.
- Load 0x0000_0013 after the above:
  - `err`=1 and `data_out`=0 in DONE.
  - A following load of 0x0000_0010 still returns 0xDEADBEEF.
- Misaligned store 0x1234_5678 to 0x0000_0011, then aligned load of 0x0000_0010:
  - The store reports `err`=1.
  - The load still returns 0xDEADBEEF.
- Aliasing with ADDR_W=10: store 0xA5A5A5A5 to 0x0000_1010, then load 0x0000_0010 → returns 0xA5A5A5A5.
- Reset mid-BUSY:
  - Store 0x0BADF00D to 0x0000_0010 and assert `rst`=0 two cycles after acceptance.
  - `stall`, `done`, `err` and `data_out` go to 0 immediately.
  - After release, a load of 0x0000_0010 returns 0xA5A5A5A5.
- LATENCY=1, with two stores followed by a load, all presented with no idle gaps:
  - `stall` is high for 2 cycles per access.
  - `done` is seen every 3rd cycle.
  - Changing `addr` and `data_in` during BUSY has no effect on the stored or returned values.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target that stalls the pipeline for LATENCY cycles, then pulses done.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W+1:0] addr_q;
  logic              wr_q;
  logic [31:0]       wdata_q, data_out_q;
  logic              done_q, err_q;
  logic [31:0]       mem [2**ADDR_W];
  logic              access, mis;
  logic [ADDR_W-1:0] idx;
  logic              unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];
  assign idx      = addr_q[ADDR_W+1:2];
  assign mis      = addr_q[1:0] != 2'd0;
  assign access   = state_q == BUSY && cnt_q == 8'd0;
  // The request cycle itself is stalled; reset forces stall low regardless of enable.
  assign stall    = rst && (state_q == BUSY || (state_q == IDLE && enable));
  assign data_out = data_out_q;
  assign done     = done_q;
  assign err      = err_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (enable) begin
          state_q <= BUSY;
          cnt_q   <= 8'(LATENCY - 1);
          addr_q  <= addr[ADDR_W+1:0];
          wr_q    <= wr;
          wdata_q <= data_in;
        end
        BUSY: if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        else begin
          state_q <= DONE;
          done_q  <= 1'b1;
          err_q   <= mis;
          if (!wr_q) data_out_q <= mis ? 32'd0 : mem[idx];
        end
        default: state_q <= IDLE;
      endcase
    end
  // Storage has no reset; an aborted access never reaches the write edge because state is forced to IDLE.
  always_ff @(posedge clk)
    if (access && wr_q && !mis) mem[idx] <= wdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives a LATENCY=4 and a LATENCY=1 responder against a word-array reference model.
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst4, en4, wr4, st4, dn4, er4, rst1, en1, wr1, st1, dn1, er1;
  logic [31:0] ad4, di4, do4, ad1, di1, do1;
  dmem_responder #(.ADDR_W(10), .LATENCY(4)) u4 (.clk(clk), .rst(rst4), .enable(en4), .wr(wr4),
    .addr(ad4), .data_in(di4), .data_out(do4), .stall(st4), .done(dn4), .err(er4));
  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u1 (.clk(clk), .rst(rst1), .enable(en1), .wr(wr1),
    .addr(ad1), .data_in(di1), .data_out(do1), .stall(st1), .done(dn1), .err(er1));
  int checks = 0, errors = 0;
  logic [31:0] mem_m [2][1024];
  logic [31:0] dout_m [2];
  int          st, dc;
  logic [31:0] q, eq;
  logic        e, ee;
  function automatic int lat(input int k);
    return k == 0 ? 4 : 1;
  endfunction
  // Reference: a word array indexed by address modulo 4 KiB; misaligned loads return 0, misaligned stores drop.
  function automatic void model(input int k, input bit w, input logic [31:0] a, d,
                                output logic [31:0] exp_q, output logic exp_e);
    int i;
    i     = int'((a >> 2) % 1024);
    exp_e = (a % 4) != 0;
    if (!w) dout_m[k] = exp_e ? 32'd0 : mem_m[k][i];
    else if (!exp_e) mem_m[k][i] = d;
    exp_q = dout_m[k];
  endfunction
  task automatic run(input int k, input bit w, input logic [31:0] a, d, input bit scr);
    bit got = 0;
    st = 0; dc = -1; q = 'x; e = 1'bx;
    if (k == 0) begin en4 = 1; wr4 = w; ad4 = a; di4 = d; end
    else begin en1 = 1; wr1 = w; ad1 = a; di1 = d; end
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if ((k == 0) ? st4 : st1) st++;
      if ((k == 0) ? dn4 : dn1) begin
        got = 1; dc = c; q = (k == 0) ? do4 : do1; e = (k == 0) ? er4 : er1;
      end
      @(posedge clk); #1;
      if (scr && !got) begin
        if (k == 0) begin ad4 = $urandom; di4 = $urandom; wr4 = 1'($urandom); end
        else begin ad1 = $urandom; di1 = $urandom; wr1 = 1'($urandom); end
      end
    end
    if (k == 0) en4 = 0; else en1 = 0;
  endtask
  task automatic test_reset();
    rst4 = 0; rst1 = 0; en4 = 1; en1 = 1; wr4 = 0; wr1 = 0; ad4 = 0; ad1 = 0; di4 = 0; di1 = 0;
    dout_m[0] = 0; dout_m[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (st4 !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", st4); end
    if (dn4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dn4); end
    if (er4 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", er4); end
    if (do4 !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", do4); end
    en4 = 0;
    @(posedge clk); #1;
    rst4 = 1;
  endtask
  task automatic test_store_load();
    logic [31:0] ta [5] = '{32'h10, 32'h10, 32'h13, 32'h11, 32'h10};
    bit          tw [5] = '{1, 0, 0, 1, 0};
    logic [31:0] td [5] = '{32'hDEADBEEF, 0, 0, 32'h12345678, 0};
    for (int i = 0; i < 5; i++) begin
      model(0, tw[i], ta[i], td[i], eq, ee);
      run(0, tw[i], ta[i], td[i], 1'b0);
      checks += 4;
      if (st !== 5) begin errors++; $display("FAIL sl_stall op%0d got %0d want 5", i, st); end
      if (dc !== 5) begin errors++; $display("FAIL sl_done_cycle op%0d got %0d want 5", i, dc); end
      if (e !== ee) begin errors++; $display("FAIL sl_err op%0d got %b want %b", i, e, ee); end
      if (q !== eq) begin errors++; $display("FAIL sl_data op%0d got %h want %h", i, q, eq); end
    end
  endtask
  task automatic test_alias();
    logic [31:0] ta [2] = '{32'h1010, 32'h10};
    bit          tw [2] = '{1, 0};
    for (int i = 0; i < 2; i++) begin
      model(0, tw[i], ta[i], 32'hA5A5A5A5, eq, ee);
      run(0, tw[i], ta[i], 32'hA5A5A5A5, 1'b0);
      checks += 3;
      if (dc !== 5) begin errors++; $display("FAIL alias_done_cycle op%0d got %0d want 5", i, dc); end
      if (e !== ee) begin errors++; $display("FAIL alias_err op%0d got %b want %b", i, e, ee); end
      if (q !== eq) begin errors++; $display("FAIL alias_data op%0d got %h want %h", i, q, eq); end
    end
  endtask
  task automatic test_reset_mid_busy();
    en4 = 1; wr4 = 1; ad4 = 32'h10; di4 = 32'h0BADF00D;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (st4 !== 1'b1) begin errors++; $display("FAIL rmb_stall_before got %b want 1", st4); end
    rst4 = 0;
    #1;
    dout_m[0] = 0;
    checks += 4;
    if (st4 !== 1'b0) begin errors++; $display("FAIL rmb_stall got %b want 0", st4); end
    if (dn4 !== 1'b0) begin errors++; $display("FAIL rmb_done got %b want 0", dn4); end
    if (er4 !== 1'b0) begin errors++; $display("FAIL rmb_err got %b want 0", er4); end
    if (do4 !== 32'd0) begin errors++; $display("FAIL rmb_data got %h want 0", do4); end
    en4 = 0;
    @(posedge clk); #1;
    rst4 = 1;
    model(0, 0, 32'h10, 0, eq, ee);
    run(0, 0, 32'h10, 0, 1'b0);
    checks += 2;
    if (dc !== 5) begin errors++; $display("FAIL rmb_load_done_cycle got %0d want 5", dc); end
    if (q !== eq) begin errors++; $display("FAIL rmb_load_data got %h want %h", q, eq); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] ta [3] = '{32'h20, 32'h24, 32'h20};
    bit          tw [3] = '{1, 1, 0};
    logic [31:0] td [3] = '{32'h11111111, 32'h22222222, 0};
    en1 = 1; wr1 = 1; ad1 = ta[0]; di1 = td[0];
    #1;
    checks++;
    if (st1 !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_reset got %b want 0", st1); end
    @(posedge clk); #1;
    rst1 = 1;
    for (int i = 0; i < 3; i++) begin
      model(1, tw[i], ta[i], td[i], eq, ee);
      run(1, tw[i], ta[i], td[i], 1'b1);
      checks += 4;
      if (st !== 2) begin errors++; $display("FAIL b2b_stall op%0d got %0d want 2", i, st); end
      if (dc !== 2) begin errors++; $display("FAIL b2b_done_cycle op%0d got %0d want 2", i, dc); end
      if (e !== ee) begin errors++; $display("FAIL b2b_err op%0d got %b want %b", i, e, ee); end
      if (q !== eq) begin errors++; $display("FAIL b2b_data op%0d got %h want %h", i, q, eq); end
    end
  endtask
  task automatic test_random();
    int k, gap;
    bit w;
    logic [31:0] a, d;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'(i % 8) << 2;
      d = $urandom;
      k = i / 8;
      model(k, 1, a, d, eq, ee);
      run(k, 1, a, d, 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 1));
      w = 1'($urandom);
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7)) << 2 |
          (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      d = $urandom;
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
      model(k, w, a, d, eq, ee);
      run(k, w, a, d, 1'b1);
      checks += 4;
      if (st !== lat(k) + 1) begin errors++; $display("FAIL rnd_stall op%0d got %0d want %0d", i, st, lat(k) + 1); end
      if (dc !== lat(k) + 1) begin errors++; $display("FAIL rnd_done_cycle op%0d got %0d want %0d", i, dc, lat(k) + 1); end
      if (e !== ee) begin errors++; $display("FAIL rnd_err op%0d got %b want %b", i, e, ee); end
      if (q !== eq) begin errors++; $display("FAIL rnd_data op%0d got %h want %h", i, q, eq); end
    end
  endtask
  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
